// File: rtl/mips_alu_exec_pipe_if.sv
// Handshake bundle for the MIPS execute pipe: issue side (in_*) and result side (out_*).
// slave is the pipe's view; master is the view of whoever feeds and drains it.
interface mips_alu_exec_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_rs;
  logic [DATA_W-1:0] in_rt;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, in_rs, in_rt, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs, in_rt, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );
endinterface

// File: rtl/mips_alu_exec_pipe.sv
// Pipelined MIPS integer execute stage: stage 0 computes, later stages only delay.
// The whole pipe advances together whenever the output slot is free or being drained.
module mips_alu_exec_pipe #(
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_alu_exec_pipe_if.slave bus,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  illegal_count
);

  logic en;
  logic out_fire;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic [DATA_W-1:0] simm;
  logic [DATA_W-1:0] zimm;
  logic [DATA_W-1:0] lui_val;
  logic [DATA_W-1:0] sra_val;
  logic signed [DATA_W-1:0] rt_s;
  logic              slti_lt;

  logic [DATA_W-1:0] res_next;
  logic              ill_next;

  logic [CNT_W-1:0]  instr_count_reg;
  logic [CNT_W-1:0]  illegal_count_reg;

  assign opcode  = bus.in_instr[31:26];
  assign funct   = bus.in_instr[5:0];
  assign shamt   = bus.in_instr[10:6];
  assign imm     = bus.in_instr[15:0];
  assign rs      = bus.in_rs;
  assign rt      = bus.in_rt;
  assign simm    = DATA_W'($signed(imm));
  assign zimm    = DATA_W'(imm);
  // For DATA_W below 32 the upper immediate bits fall off the top.
  assign lui_val = DATA_W'({imm, 16'h0000});
  assign rt_s    = $signed(rt);
  assign sra_val = rt_s >>> shamt;
  assign slti_lt = $signed(rs) < $signed(simm);

  always_comb begin
    res_next = '0;
    ill_next = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   res_next = rs + rt;
          6'h22:   res_next = rs - rt;
          6'h24:   res_next = rs & rt;
          6'h25:   res_next = rs | rt;
          6'h00:   res_next = rt << shamt;
          6'h02:   res_next = rt >> shamt;
          6'h03:   res_next = sra_val;
          6'h2B:   res_next = {{(DATA_W-1){1'b0}}, (rs < rt)};
          default: ill_next = 1'b1;
        endcase
      end
      6'h08, 6'h09: res_next = rs + simm;
      6'h0C:        res_next = rs & zimm;
      6'h0D:        res_next = rs | zimm;
      6'h0A:        res_next = {{(DATA_W-1){1'b0}}, slti_lt};
      6'h0F:        res_next = lui_val;
      default:      ill_next = 1'b1;
    endcase
  end

  assign en           = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;
  assign out_fire     = bus.out_valid & bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      logic              vld_reg;
      logic [DATA_W-1:0] res_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic              ill_reg;
      logic              vld_next;
      logic [DATA_W-1:0] res_stage_next;
      logic [TAG_W-1:0]  tag_next;
      logic              ill_stage_next;

      if (gi == 0) begin : g_head
        assign vld_next       = bus.in_valid;
        assign res_stage_next = res_next;
        assign tag_next       = bus.in_tag;
        assign ill_stage_next = ill_next;
      end else begin : g_tail
        assign vld_next       = g_stage[gi-1].vld_reg;
        assign res_stage_next = g_stage[gi-1].res_reg;
        assign tag_next       = g_stage[gi-1].tag_reg;
        assign ill_stage_next = g_stage[gi-1].ill_reg;
      end

      // Bubbles shift like real entries so latency stays fixed at PIPE_DEPTH.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg <= 1'b0;
          res_reg <= '0;
          tag_reg <= '0;
          ill_reg <= 1'b0;
        end else if (en) begin
          vld_reg <= vld_next;
          res_reg <= res_stage_next;
          tag_reg <= tag_next;
          ill_reg <= ill_stage_next;
        end
      end
    end
  endgenerate

  assign bus.out_valid   = g_stage[PIPE_DEPTH-1].vld_reg;
  assign bus.out_result  = g_stage[PIPE_DEPTH-1].res_reg;
  assign bus.out_tag     = g_stage[PIPE_DEPTH-1].tag_reg;
  assign bus.out_illegal = g_stage[PIPE_DEPTH-1].ill_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_reg   <= '0;
      illegal_count_reg <= '0;
    end else if (out_fire) begin
      if (instr_count_reg != '1)
        instr_count_reg <= instr_count_reg + CNT_W'(1);
      if (bus.out_illegal && (illegal_count_reg != '1))
        illegal_count_reg <= illegal_count_reg + CNT_W'(1);
    end
  end

  assign instr_count   = instr_count_reg;
  assign illegal_count = illegal_count_reg;

endmodule

// File: tb/tb_mips_alu_exec_pipe.sv
// Self-checking bench for mips_alu_exec_pipe: directed cases plus a randomized stream
// compared against an instruction-level reference model through expected/observed queues.
module tb_mips_alu_exec_pipe;
  localparam int DW   = 32;
  localparam int PD   = 2;
  localparam int TW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          ill;
    int            cyc;
  } item_t;

  logic clk;
  logic rst_n;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] illegal_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_issued = 0;
  int n_ill = 0;
  bit rnd_run = 0;
  bit b2b_done = 0;
  item_t exp_q[$];
  item_t obs_q[$];

  mips_alu_exec_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  mips_alu_exec_pipe #(.DATA_W(DW), .PIPE_DEPTH(PD), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .instr_count   (instr_count),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Everything the pipe hands over is recorded with the cycle it left.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready)
      obs_q.push_back('{bus.out_result, bus.out_tag, bus.out_illegal, cyc});
  end

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Reference semantics straight from the MIPS instruction definitions.
  function automatic void model(input logic [31:0] ins, input logic [31:0] rs,
                                input logic [31:0] rt, output logic [31:0] r, output logic ill);
    logic [5:0]  op, fn;
    int          sh;
    logic [31:0] simm, zimm;
    int          a, b;
    op = ins[31:26]; fn = ins[5:0]; sh = int'(ins[10:6]);
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    r = 32'h0; ill = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: r = rs + rt;
        6'h22: r = rs - rt;
        6'h24: r = rs & rt;
        6'h25: r = rs | rt;
        6'h00: r = rt << sh;
        6'h02: r = rt >> sh;
        6'h03: r = (rt >> sh) | (rt[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        6'h2B: r = (rs < rt) ? 32'd1 : 32'd0;
        default: ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: r = rs + simm;
        6'h0C: r = rs & zimm;
        6'h0D: r = rs | zimm;
        6'h0A: begin a = rs; b = simm; r = (a < b) ? 32'd1 : 32'd0; end
        6'h0F: r = {ins[15:0], 16'h0000};
        default: ill = 1'b1;
      endcase
    end
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 15'h0, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'h0, imm};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [3:0] tag);
    bit ok;
    item_t e;
    bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_rs = rs; bus.in_rt = rt; bus.in_tag = tag;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_accept instr=%08h in_ready stayed 0, required 1 within 200 cycles", ins);
    end else begin
      model(ins, rs, rt, e.res, e.ill);
      e.tag = tag; e.cyc = 0;
      exp_q.push_back(e);
      n_issued++;
      if (e.ill) n_ill++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (obs_q.size() >= exp_q.size()) begin ok = 1; break; end
      idle(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks += 7;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b required 0", bus.out_valid); end
    if (bus.out_result !== '0) begin errors++; $display("FAIL reset_out_result got %08h required 0", bus.out_result); end
    if (bus.out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %0h required 0", bus.out_tag); end
    if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal got %0b required 0", bus.out_illegal); end
    if (instr_count !== '0) begin errors++; $display("FAIL reset_instr_count got %0d required 0", instr_count); end
    if (illegal_count !== '0) begin errors++; $display("FAIL reset_illegal_count got %0d required 0", illegal_count); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b required 1", bus.in_ready); end
    $display("test_reset: done, errors so far %0d", errors);
  endtask

  task automatic test_add();
    item_t e, o;
    bus.out_ready = 1'b1;
    issue(rtype(6'h20, 5'd0), 32'd5, 32'd7, 4'd3);
    for (int k = 0; k < PD - 1; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid cycle %0d got %0b required 0", k, bus.out_valid); end
      idle(1);
    end
    checks += 4;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_latency_valid got %0b required 1", bus.out_valid); end
    if (bus.out_result !== 32'd12) begin errors++; $display("FAIL add_result got %08h required 0000000c", bus.out_result); end
    if (bus.out_tag !== 4'd3) begin errors++; $display("FAIL add_tag got %0h required 3", bus.out_tag); end
    if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got %0b required 0", bus.out_illegal); end
    drain();
    idle(1);
    checks++;
    if (instr_count !== CW'(1)) begin errors++; $display("FAIL add_instr_count got %0d required 1", instr_count); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.res !== e.res || o.tag !== e.tag || o.ill !== e.ill) begin
        errors++; $display("FAIL add_queue got %08h/%0h/%0b required %08h/%0h/%0b", o.res, o.tag, o.ill, e.res, e.tag, e.ill);
      end
    end
    $display("test_add: done, errors so far %0d", errors);
  endtask

  task automatic test_shifts();
    item_t e, o;
    logic [31:0] want [3];
    want[0] = 32'hF800_0000; want[1] = 32'h0800_0000; want[2] = 32'h8000_0000;
    issue(rtype(6'h03, 5'd4), 32'h0, 32'h8000_0000, 4'd4);
    issue(rtype(6'h02, 5'd4), 32'h0, 32'h8000_0000, 4'd5);
    issue(rtype(6'h00, 5'd31), 32'h0, 32'h1, 4'd6);
    drain();
    for (int k = 0; k < 3 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks += 2;
      if (o.res !== want[k]) begin errors++; $display("FAIL shift_%0d got %08h required %08h", k, o.res, want[k]); end
      if (o.tag !== e.tag || o.ill !== 1'b0) begin errors++; $display("FAIL shift_side_%0d got %0h/%0b required %0h/0", k, o.tag, o.ill, e.tag); end
    end
    exp_q.delete(); obs_q.delete();
    $display("test_shifts: done, errors so far %0d", errors);
  endtask

  task automatic test_imm();
    item_t o;
    logic [31:0] want [4];
    want[0] = 32'd1; want[1] = 32'd0; want[2] = 32'h0000_8000; want[3] = 32'h1234_0000;
    issue(itype(6'h0A, 16'h0001), 32'hFFFF_FFFF, 32'h0, 4'd7);
    issue(rtype(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'h1, 4'd8);
    issue(itype(6'h0C, 16'h8000), 32'hFFFF_FFFF, 32'h0, 4'd9);
    issue(itype(6'h0F, 16'h1234), 32'hDEAD_BEEF, 32'h0, 4'd10);
    drain();
    for (int k = 0; k < 4 && obs_q.size() > 0; k++) begin
      o = obs_q.pop_front(); checks += 2;
      if (o.res !== want[k]) begin errors++; $display("FAIL imm_%0d got %08h required %08h", k, o.res, want[k]); end
      if (o.tag !== 4'(7 + k)) begin errors++; $display("FAIL imm_tag_%0d got %0h required %0h", k, o.tag, 7 + k); end
    end
    exp_q.delete(); obs_q.delete();
    $display("test_imm: done, errors so far %0d", errors);
  endtask

  task automatic test_back_to_back();
    item_t e, o;
    bit ok;
    int first_cyc;
    bus.out_ready = 1'b0;
    b2b_done = 0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          issue(rtype(6'h22, 5'd0), 32'(100 * (k + 1)), 32'(k), 4'(8 + k));
        b2b_done = 1;
      end
    join_none
    idle(5);
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid got %0b required 1", bus.out_valid); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready got %0b required 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (b2b_done) begin ok = 1; break; end
      idle(1);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_issue_done got 0 required 1 within 100 cycles"); end
    drain();
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL b2b_count got %0d required 4", obs_q.size()); end
    first_cyc = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
    for (int k = 0; k < 4 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks += 2;
      if (o.res !== e.res || o.tag !== e.tag || o.ill !== e.ill) begin
        errors++; $display("FAIL b2b_order_%0d got %08h/%0h required %08h/%0h", k, o.res, o.tag, e.res, e.tag);
      end
      if (o.cyc != first_cyc + k) begin errors++; $display("FAIL b2b_rate_%0d got cycle %0d required %0d", k, o.cyc, first_cyc + k); end
    end
    exp_q.delete(); obs_q.delete();
    $display("test_back_to_back: done, errors so far %0d", errors);
  endtask

  task automatic test_illegal();
    item_t e, o;
    issue(32'hFC00_0000, 32'h1234_5678, 32'h1, 4'd1);
    issue(32'h0000_003F, 32'h1234_5678, 32'h1, 4'd2);
    issue(rtype(6'h20, 5'd0), 32'd40, 32'd2, 4'd3);
    drain();
    idle(1);
    for (int k = 0; k < 3 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.res !== e.res || o.tag !== e.tag || o.ill !== e.ill) begin
        errors++; $display("FAIL illegal_%0d got %08h/%0h/%0b required %08h/%0h/%0b", k, o.res, o.tag, o.ill, e.res, e.tag, e.ill);
      end
    end
    checks += 2;
    if (illegal_count !== CW'(sat(n_ill))) begin errors++; $display("FAIL illegal_count got %0d required %0d", illegal_count, sat(n_ill)); end
    if (instr_count !== CW'(sat(n_issued))) begin errors++; $display("FAIL illegal_instr_count got %0d required %0d", instr_count, sat(n_issued)); end
    exp_q.delete(); obs_q.delete();
    $display("test_illegal: done, errors so far %0d", errors);
  endtask

  task automatic test_random();
    item_t e, o;
    logic [5:0] ops [15];
    logic [5:0] fns [15];
    int sel;
    logic [31:0] ins;
    ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0F, 6'h0B};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03, 6'h2B,
            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    rnd_run = 1;
    fork
      begin
        while (rnd_run) begin bus.out_ready = 1'($urandom_range(0, 1)); idle(1); end
      end
    join_none
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 16);
      if (sel == 15)      ins = {6'h00, 20'($urandom), 6'h21};
      else if (sel == 16) ins = {6'($urandom_range(16, 63)), 26'($urandom)};
      else if (ops[sel] == 6'h00) ins = {6'h00, 15'($urandom), 5'($urandom), fns[sel]};
      else                ins = {ops[sel], 10'($urandom), 16'($urandom)};
      issue(ins, $urandom, $urandom, 4'($urandom));
      idle($urandom_range(0, 2));
    end
    rnd_run = 0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    drain();
    idle(1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.res !== e.res || o.tag !== e.tag || o.ill !== e.ill) begin
        errors++; $display("FAIL rand_item got %08h/%0h/%0b required %08h/%0h/%0b", o.res, o.tag, o.ill, e.res, e.tag, e.ill);
      end
    end
    checks += 2;
    if (instr_count !== CW'(sat(n_issued))) begin errors++; $display("FAIL sat_instr_count got %0d required %0d", instr_count, sat(n_issued)); end
    if (illegal_count !== CW'(sat(n_ill))) begin errors++; $display("FAIL sat_illegal_count got %0d required %0d", illegal_count, sat(n_ill)); end
    exp_q.delete(); obs_q.delete();
    $display("test_random: %0d retired, errors so far %0d", n_issued, errors);
  endtask

  task automatic test_midreset();
    item_t e, o;
    bus.out_ready = 1'b0;
    issue(rtype(6'h20, 5'd0), 32'd1, 32'd2, 4'd5);
    issue(rtype(6'h25, 5'd0), 32'd4, 32'd8, 4'd6);
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b required 0", bus.out_valid); end
    if (bus.out_result !== '0) begin errors++; $display("FAIL mid_rst_result got %08h required 0", bus.out_result); end
    if (bus.out_tag !== '0) begin errors++; $display("FAIL mid_rst_tag got %0h required 0", bus.out_tag); end
    if (instr_count !== '0) begin errors++; $display("FAIL mid_rst_instr_count got %0d required 0", instr_count); end
    if (illegal_count !== '0) begin errors++; $display("FAIL mid_rst_illegal_count got %0d required 0", illegal_count); end
    exp_q.delete(); obs_q.delete(); n_issued = 0; n_ill = 0;
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(10);
    checks += 2;
    if (obs_q.size() != 0) begin errors++; $display("FAIL mid_rst_ghost got %0d results required 0", obs_q.size()); end
    if (instr_count !== '0) begin errors++; $display("FAIL mid_rst_after_count got %0d required 0", instr_count); end
    issue(itype(6'h0D, 16'h00F0), 32'h0000_0F00, 32'h0, 4'd9);
    drain();
    idle(1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.res !== e.res || o.tag !== e.tag || o.ill !== e.ill) begin
        errors++; $display("FAIL mid_rst_resume got %08h/%0h required %08h/%0h", o.res, o.tag, e.res, e.tag);
      end
    end
    checks++;
    if (instr_count !== CW'(1)) begin errors++; $display("FAIL mid_rst_resume_count got %0d required 1", instr_count); end
    $display("test_midreset: done, errors so far %0d", errors);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    test_reset();
    test_add();
    test_shifts();
    test_imm();
    test_back_to_back();
    test_illegal();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
